// File: rtl/data_read_mux.sv
// data_read_mux: region-decoded read-return mux with wait, timeout and unmapped-error handling.
// Define DATAMUX_PARITY_EN to add a registered per-byte parity output (DataParity).
module data_read_mux #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 16,
  parameter int SEL_W = 4,
  parameter int NUM_SRC = 6,
  parameter logic [NUM_SRC-1:0] SRC_MAP = 6'b111101,
  parameter int TIMEOUT = 15
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      nRead,
  input  logic [ADDR_W-1:0]         address,
  input  logic [NUM_SRC*DATA_W-1:0] SrcDataIn,
  input  logic [NUM_SRC-1:0]        SrcValid,
  output logic [DATA_W-1:0]         DataMuxOut,
  output logic                      DataValid,
  output logic                      Busy,
  output logic                      ErrUnmapped,
  output logic                      ErrTimeout
`ifdef DATAMUX_PARITY_EN
  , output logic [DATA_W/8-1:0]     DataParity
`endif
);
  localparam int NSEL = 2**SEL_W;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t r_state, w_state_nx;
  logic [SEL_W-1:0] r_sel, w_sel_nx, w_sel;
  logic [7:0] r_timer, w_timer_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;
  logic r_valid, w_valid_nx, r_err_unm, w_err_unm_nx, r_err_to, w_err_to_nx;
  logic [DATA_W-1:0] w_ch [NSEL];
  logic [NSEL-1:0] w_vld, w_map;
  logic w_unused;
  // Channels beyond NUM_SRC are padded so any select value indexes safely.
  for (genvar g = 0; g < NSEL; g++) begin : g_ch
    if (g < NUM_SRC) begin : g_live
      assign w_ch[g] = SrcDataIn[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign w_ch[g] = '0;
    end
  end
  assign w_vld = NSEL'(SrcValid);
  assign w_map = NSEL'(SRC_MAP);
  assign w_sel = address[ADDR_W-1 -: SEL_W];
  assign w_unused = ^address[ADDR_W-SEL_W-1:0];
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx = r_sel;
    w_timer_nx = r_timer;
    w_data_nx = r_data;
    w_valid_nx = 1'b0;
    w_err_unm_nx = 1'b0;
    w_err_to_nx = 1'b0;
    if (r_state == S_IDLE) begin
      if (!nRead) begin
        if (w_map[w_sel]) begin
          w_state_nx = S_WAIT;
          w_sel_nx = w_sel;
          w_timer_nx = '0;
        end else begin
          w_err_unm_nx = 1'b1;
        end
      end
    end else if (w_vld[r_sel]) begin
      w_data_nx = w_ch[r_sel];
      w_valid_nx = 1'b1;
      w_state_nx = S_IDLE;
    end else if (r_timer == 8'(TIMEOUT-1)) begin
      w_err_to_nx = 1'b1;
      w_state_nx = S_IDLE;
    end else begin
      w_timer_nx = r_timer + 8'd1;
    end
  end
`ifdef DATAMUX_PARITY_EN
  logic [DATA_W/8-1:0] r_par, w_par;
  always_comb begin
    w_par = '0;
    for (int k = 0; k < DATA_W/8; k++) w_par[k] = ^w_ch[r_sel][8*k +: 8];
  end
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) r_par <= '0;
    else if (w_valid_nx) r_par <= w_par;
  end
  assign DataParity = r_par;
`endif
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_sel <= '0;
      r_timer <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_err_unm <= 1'b0;
      r_err_to <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sel <= w_sel_nx;
      r_timer <= w_timer_nx;
      r_data <= w_data_nx;
      r_valid <= w_valid_nx;
      r_err_unm <= w_err_unm_nx;
      r_err_to <= w_err_to_nx;
    end
  end
  assign DataMuxOut = r_data;
  assign DataValid = r_valid;
  assign Busy = (r_state == S_WAIT);
  assign ErrUnmapped = r_err_unm;
  assign ErrTimeout = r_err_to;
endmodule

// File: tb/tb_data_read_mux.sv
// tb_data_read_mux: directed bench for data_read_mux with an expected-data scoreboard queue.
module tb_data_read_mux;
  localparam int DW = 256;
  localparam int NS = 6;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic nRead = 1'b1;
  logic [15:0] address = '0;
  logic [NS*DW-1:0] SrcDataIn = '0;
  logic [NS-1:0] SrcValid = '0;
  logic [DW-1:0] DataMuxOut;
  logic DataValid, Busy, ErrUnmapped, ErrTimeout;
`ifdef DATAMUX_PARITY_EN
  logic [DW/8-1:0] DataParity;
`endif
  logic [DW-1:0] q [$];
  int npass = 0;
  int ntot = 0;
  int pulses;

  data_read_mux dut (
    .Clk(Clk), .nReset(nReset), .nRead(nRead), .address(address),
    .SrcDataIn(SrcDataIn), .SrcValid(SrcValid), .DataMuxOut(DataMuxOut),
    .DataValid(DataValid), .Busy(Busy), .ErrUnmapped(ErrUnmapped), .ErrTimeout(ErrTimeout)
`ifdef DATAMUX_PARITY_EN
    , .DataParity(DataParity)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d);
    SrcDataIn[ch*DW +: DW] = d;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clk);
      if (DataValid === 1'b1) got = 1'b1;
    end
    chk({tag, "_seen"}, DW'(got), DW'(1));
    if (got) begin
      chk({tag, "_err"}, DW'({ErrTimeout, ErrUnmapped, Busy}), '0);
      if (q.size() > 0) chk({tag, "_data"}, DataMuxOut, q.pop_front());
      else chk({tag, "_sb_empty"}, DW'(q.size()), DW'(1));
    end
  endtask

  task automatic request(input logic [15:0] a);
    @(negedge Clk);
    nRead = 1'b0;
    address = a;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_data", DataMuxOut, '0);
    chk("rst_flags", DW'({DataValid, Busy, ErrUnmapped, ErrTimeout}), '0);
    nReset = 1'b1;
    // immediate valid: two-cycle latency
    set_ch(0, DW'('hA5));
    SrcValid = 6'b000001;
    request(16'h0040);
    q.push_back(DW'('hA5));
    @(negedge Clk);
    nRead = 1'b1;
    chk("t1_busy", DW'({Busy, DataValid}), DW'(2'b10));
    wait_valid("t1", 1);
    @(negedge Clk);
    chk("t1_pulse_end", DW'(DataValid), '0);
    SrcValid = '0;
    // delayed source: five WAIT cycles with valid low
    set_ch(3, DW'('h1234));
    request(16'h3000);
    @(negedge Clk);
    nRead = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      pulses += int'(DataValid | ErrTimeout | ErrUnmapped | !Busy);
    end
    chk("t2_waiting", DW'(pulses), '0);
    @(negedge Clk);
    SrcValid = 6'b001000;
    q.push_back(DW'('h1234));
    wait_valid("t2", 1);
    SrcValid = '0;
    // unmapped regions
    request(16'h1000);
    @(negedge Clk);
    nRead = 1'b1;
    chk("t3a_err", DW'({ErrUnmapped, Busy, DataValid}), DW'(3'b100));
    chk("t3a_hold", DataMuxOut, DW'('h1234));
    @(negedge Clk);
    chk("t3a_pulse_end", DW'(ErrUnmapped), '0);
    request(16'h7000);
    @(negedge Clk);
    nRead = 1'b1;
    chk("t3b_err", DW'({ErrUnmapped, Busy, DataValid}), DW'(3'b100));
    chk("t3b_hold", DataMuxOut, DW'('h1234));
    @(negedge Clk);
    chk("t3b_pulse_end", DW'(ErrUnmapped), '0);
    // timeout after 15 WAIT cycles
    request(16'h4000);
    @(negedge Clk);
    nRead = 1'b1;
    repeat (14) @(negedge Clk);
    chk("t4_last_wait", DW'({Busy, ErrTimeout}), DW'(2'b10));
    @(negedge Clk);
    chk("t4_timeout", DW'({ErrTimeout, Busy, DataValid, ErrUnmapped}), DW'(4'b1000));
    chk("t4_hold", DataMuxOut, DW'('h1234));
    @(negedge Clk);
    chk("t4_pulse_end", DW'(ErrTimeout), '0);
    // valid arriving on the timeout cycle wins
    set_ch(2, DW'('h0103));
    request(16'h2000);
    @(negedge Clk);
    nRead = 1'b1;
    repeat (14) @(negedge Clk);
    SrcValid = 6'b000100;
    q.push_back(DW'('h0103));
    wait_valid("t5", 1);
`ifdef DATAMUX_PARITY_EN
    chk("t5_parity", DW'(DataParity), DW'(2'b10));
`endif
    SrcValid = '0;
    // back-to-back with nRead held low
    set_ch(0, DW'('h55));
    SrcValid = 6'b000001;
    request(16'h0040);
    q.push_back(DW'('h55));
    @(negedge Clk);
    chk("t6_busy1", DW'(Busy), DW'(1));
    wait_valid("t6a", 1);
    set_ch(0, DW'('h66));
    q.push_back(DW'('h66));
    @(negedge Clk);
    nRead = 1'b1;
    chk("t6_busy2", DW'(Busy), DW'(1));
    wait_valid("t6b", 1);
    SrcValid = '0;
    // wrong-channel valid, then reset mid-WAIT
    SrcValid = 6'b000001;
    request(16'h5000);
    @(negedge Clk);
    nRead = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge Clk);
      pulses += int'(DataValid);
    end
    chk("t7_no_valid", DW'({Busy, 2'(pulses)}), DW'(3'b100));
    #2 nReset = 1'b0;
    #1 chk("t7_async_rst", DW'({DataValid, Busy, ErrUnmapped, ErrTimeout}), '0);
    chk("t7_rst_data", DataMuxOut, '0);
    @(negedge Clk);
    nReset = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge Clk);
      pulses += int'(DataValid | ErrTimeout | ErrUnmapped | Busy);
    end
    chk("t7_quiet", DW'(pulses), '0);
    chk("sb_drained", DW'(q.size()), '0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
